ca_fitness_evaluator: RTL and testbench
=======================================

Name: ca_fitness_evaluator

Overview:
- Downstream consumer of the binary cellular automaton's state bus. Also acts as its run controller: loads the seed, enables evolution for up to max_gen generations, and scores each run.
- Scoring: accumulates the live-cell population per generation. Terminates early on extinction (no live cells) or stasis (state unchanged between generations).
- Produces a fitness word and status for the genetic search loop.

Parameters:
- Width, 4, CA grid width in cells.
- Height, 4, CA grid height in cells.
- GenWidth, 16, width of the generation counter and max_gen.
- AccWidth, 24, width of the fitness accumulator (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- max_gen  in  GenWidth  generation limit; sampled on accepted start.
- state  in  Width*Height  CA state bus.
- ca_load  out  1  one-cycle pulse to the CA rst input (loads the seed from its set input).
- ca_ce  out  1  CA clock enable.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when results become valid.
- fitness  out  AccWidth  sum of per-generation populations.
- gen_count  out  GenWidth  number of generations sampled.
- status  out  2  0 none, 1 limit, 2 static, 3 extinct.

Behaviour:
- Reset: FSM to IDLE. ca_load, ca_ce, busy, done = 0. fitness, gen_count, status = 0. Previous-state register = 0.
- Reset mid-run aborts immediately with the same values; no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 latches max_gen and clears fitness, gen_count, status.
  - Next state is LOAD; busy goes 1 in the following cycle.
- LOAD: ca_load=1 for exactly one cycle.
  - If the latched max_gen == 0: go to DONE with status=1, fitness=0, gen_count=0.
  - Otherwise go to RUN.
- RUN: ca_ce=1 combinationally while in RUN. On each RUN clock edge, with pop = popcount(state):
  - state is treated as generation gen_count (generation 0 = seed).
  - fitness <= fitness + pop, saturating at all-ones.
  - gen_count <= gen_count + 1.
  - prev <= state.
- RUN termination, evaluated on the same sample; priority extinct > static > limit:
  - extinct: pop == 0 -> status 3.
  - static: gen_count > 0 and state == prev -> status 2.
  - limit: gen_count + 1 == latched max_gen -> status 1.
  - Any hit -> DONE.
  - On the terminating sample, ca_ce is still 1, so the CA advances once more. Downstream ignores this extra generation.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Result holding: fitness, gen_count and status hold until the next accepted start.
- start while busy is ignored. start held high in IDLE after DONE starts a new run.
- popcount width: clog2(Width*Height+1). Zero-extended to AccWidth before the add.
- Latency from start to done: max_gen + 2 cycles (no early exit, max_gen ≥ 1).

Test Plan (4x4; tests 1-4 use a bench stub driving state directly):
1. Stub alternates state 16'h000F / 16'h00F0 each cycle; start, max_gen=5 -> done 7 cycles after start; fitness=20, gen_count=5, status=1; ca_load pulsed once; ca_ce high exactly 5 cycles.
2. Stub holds 16'h0000 -> first RUN sample terminates; fitness=0, gen_count=1, status=3.
3. Stub holds 16'h0660 -> terminates on second sample; fitness=8, gen_count=2, status=2. Repeat with 16'h0000 to confirm extinct wins over static at gen 0.
4. AccWidth=4, stub alternates 16'hFFFF / 16'h7FFF, max_gen=3 -> fitness saturates at 4'hF, gen_count=3, status=1.
5. max_gen=0 -> one ca_load pulse, no ca_ce, done 2 cycles after start; fitness=0, gen_count=0, status=1. Then assert rst during RUN of a max_gen=100 run -> next cycle all outputs 0, no done; start asserted during busy is ignored.
6. With the real CA: survive=9'b000001100, rise=9'b000001000, seed 16'h0660 (2x2 block), max_gen=50 -> status=2, gen_count=2, fitness=8.

Source files
------------

// File: rtl/ca_fitness_evaluator.sv
// Run controller and scorer for a binary cellular automaton: seeds the CA, steps it
// for up to max_gen generations, accumulates per-generation population and classifies the ending.
module ca_fitness_evaluator #(
  parameter int Width    = 4,
  parameter int Height   = 4,
  parameter int GenWidth = 16,
  parameter int AccWidth = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [GenWidth-1:0]       max_gen,
  input  logic [Width*Height-1:0]   state,
  output logic                      ca_load,
  output logic                      ca_ce,
  output logic                      busy,
  output logic                      done,
  output logic [AccWidth-1:0]       fitness,
  output logic [GenWidth-1:0]       gen_count,
  output logic [1:0]                status
);

  localparam int unsigned Cells    = Width * Height;
  localparam int unsigned PopWidth = $clog2(Cells + 1);

  localparam logic [1:0] StNone    = 2'd0;
  localparam logic [1:0] StLimit   = 2'd1;
  localparam logic [1:0] StStatic  = 2'd2;
  localparam logic [1:0] StExtinct = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fsm_t;

  fsm_t                  fsm;
  logic [GenWidth-1:0]   max_gen_q;
  logic [Cells-1:0]      prev;
  logic [PopWidth-1:0]   pop;
  logic [AccWidth:0]     sum;
  logic [AccWidth-1:0]   fit_next;
  logic [GenWidth-1:0]   gen_next;
  logic                  hit_extinct;
  logic                  hit_static;
  logic                  hit_limit;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < Cells; i++) begin
      pop = pop + PopWidth'(state[i]);
    end
  end

  // One extra accumulator bit catches the carry out; any carry clamps to all-ones.
  assign sum         = {1'b0, fitness} + (AccWidth + 1)'(pop);
  assign fit_next    = sum[AccWidth] ? '1 : sum[AccWidth-1:0];
  assign gen_next    = gen_count + GenWidth'(1);
  assign hit_extinct = (pop == '0);
  assign hit_static  = (gen_count != '0) && (state == prev);
  assign hit_limit   = (gen_next == max_gen_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      max_gen_q <= '0;
      prev      <= '0;
      fitness   <= '0;
      gen_count <= '0;
      status    <= StNone;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            max_gen_q <= max_gen;
            fitness   <= '0;
            gen_count <= '0;
            status    <= StNone;
            fsm       <= LOAD;
          end
        end
        LOAD: begin
          if (max_gen_q == '0) begin
            status <= StLimit;
            fsm    <= DONE;
          end else begin
            fsm <= RUN;
          end
        end
        RUN: begin
          fitness   <= fit_next;
          gen_count <= gen_next;
          prev      <= state;
          if (hit_extinct) begin
            status <= StExtinct;
            fsm    <= DONE;
          end else if (hit_static) begin
            status <= StStatic;
            fsm    <= DONE;
          end else if (hit_limit) begin
            status <= StLimit;
            fsm    <= DONE;
          end
        end
        DONE: fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign ca_load = (fsm == LOAD);
  assign ca_ce   = (fsm == RUN);
  assign busy    = (fsm == LOAD) || (fsm == RUN);
  assign done    = (fsm == DONE);

endmodule

// File: tb/tb_ca_fitness_evaluator.sv
// Scoreboard bench for ca_fitness_evaluator: a stub stands in for the CA, a reference
// model predicts each run's result and monitors compare on every done pulse.
module tb_ca_fitness_evaluator;

  typedef struct {
    int fit;
    int gen;
    int st;
    int issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] max_gen = '0;
  logic [15:0] state_bus;

  logic        ca_load_a, ca_ce_a, busy_a, done_a;
  logic [23:0] fit_a;
  logic [15:0] gen_a;
  logic [1:0]  st_a;

  logic        ca_load_b, ca_ce_b, busy_b, done_b;
  logic [3:0]  fit_b;
  logic [15:0] gen_b;
  logic [1:0]  st_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] seq [8];
  int seq_len = 1;
  int idx = 0;

  exp_t qa[$];
  exp_t qb[$];
  int ce_a = 0, ld_a = 0, ce_b = 0, ld_b = 0;

  ca_fitness_evaluator #(.Width(4), .Height(4), .GenWidth(16), .AccWidth(24)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .max_gen(max_gen), .state(state_bus),
    .ca_load(ca_load_a), .ca_ce(ca_ce_a), .busy(busy_a), .done(done_a),
    .fitness(fit_a), .gen_count(gen_a), .status(st_a)
  );

  ca_fitness_evaluator #(.Width(4), .Height(4), .GenWidth(16), .AccWidth(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .max_gen(max_gen), .state(state_bus),
    .ca_load(ca_load_b), .ca_ce(ca_ce_b), .busy(busy_b), .done(done_b),
    .fitness(fit_b), .gen_count(gen_b), .status(st_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CA stub: load rewinds to the seed, each enabled edge steps one generation.
  always @(posedge clk) begin
    if (ca_load_a | ca_load_b) idx <= 0;
    else if (ca_ce_a | ca_ce_b) idx <= idx + 1;
  end
  assign state_bus = seq[idx % seq_len];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input int fit, input int gen,
                              input int st, input int ce, input int ld);
    chk({tag, " fitness"}, fit, e.fit);
    chk({tag, " gen_count"}, gen, e.gen);
    chk({tag, " status"}, st, e.st);
    chk({tag, " latency"}, cyc - e.issue, e.gen + 2);
    chk({tag, " ca_ce cycles"}, ce, e.gen);
    chk({tag, " ca_load pulses"}, ld, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ce_a <= 0;
      ld_a <= 0;
    end else if (done_a) begin
      if (qa.size() == 0) chk("A unexpected done", 1, 0);
      else check_result("A", qa.pop_front(), int'(fit_a), int'(gen_a), int'(st_a), ce_a, ld_a);
      ce_a <= 0;
      ld_a <= 0;
    end else begin
      ce_a <= ce_a + int'(ca_ce_a);
      ld_a <= ld_a + int'(ca_load_a);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      ce_b <= 0;
      ld_b <= 0;
    end else if (done_b) begin
      if (qb.size() == 0) chk("B unexpected done", 1, 0);
      else check_result("B", qb.pop_front(), int'(fit_b), int'(gen_b), int'(st_b), ce_b, ld_b);
      ce_b <= 0;
      ld_b <= 0;
    end else begin
      ce_b <= ce_b + int'(ca_ce_b);
      ld_b <= ld_b + int'(ca_load_b);
    end
  end

  // Reference: walk the generation sequence and apply the scoring rules directly.
  function automatic exp_t model(input int maxg, input int accw);
    exp_t e;
    int cap;
    int pop;
    logic [15:0] s;
    logic [15:0] prv;
    cap = (1 << accw) - 1;
    e.fit = 0;
    e.gen = 0;
    e.st = 1;
    e.issue = 0;
    prv = '0;
    for (int g = 0; g < maxg; g++) begin
      s = seq[g % seq_len];
      pop = $countones(s);
      e.fit = (e.fit + pop > cap) ? cap : e.fit + pop;
      e.gen = g + 1;
      if (pop == 0) begin
        e.st = 3;
        break;
      end
      if (g > 0 && s == prv) begin
        e.st = 2;
        break;
      end
      prv = s;
    end
    return e;
  endfunction

  function automatic exp_t mk(input int fit, input int gen, input int st);
    exp_t e;
    e.fit = fit;
    e.gen = gen;
    e.st = st;
    e.issue = 0;
    return e;
  endfunction

  task automatic run(input bit use_b, input int maxg, input exp_t e, input bit poke);
    @(negedge clk);
    max_gen = 16'(maxg);
    e.issue = cyc;
    if (use_b) begin
      qb.push_back(e);
      start_b = 1'b1;
    end else begin
      qa.push_back(e);
      start_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    if (poke && e.gen >= 2) begin
      repeat (2) @(negedge clk);
      max_gen = 16'($urandom);
      if (use_b) start_b = 1'b1;
      else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
    end
    while (cyc < e.issue + e.gen + 5) @(negedge clk);
    chk(use_b ? "B drain" : "A drain", use_b ? qb.size() : qa.size(), 0);
  endtask

  task automatic set2(input logic [15:0] s0, input logic [15:0] s1);
    seq[0] = s0;
    seq[1] = s1;
    seq_len = 2;
  endtask

  task automatic randomize_seq();
    int r;
    seq_len = $urandom_range(1, 6);
    for (int i = 0; i < seq_len; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) seq[i] = '0;
      else if (r < 3 && i > 0) seq[i] = seq[i-1];
      else seq[i] = 16'($urandom);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int mg;
    for (int i = 0; i < 8; i++) seq[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset ca_load", ca_load_a, 0);
    chk("reset ca_ce", ca_ce_a, 0);
    chk("reset fitness", fit_a, 0);
    chk("reset gen_count", gen_a, 0);
    chk("reset status", st_a, 0);
    rst = 1'b0;

    set2(16'h000F, 16'h00F0);
    run(1'b0, 5, mk(20, 5, 1), 1'b1);
    set2(16'h0000, 16'h0000);
    run(1'b0, 5, mk(0, 1, 3), 1'b0);
    set2(16'h0660, 16'h0660);
    run(1'b0, 50, mk(8, 2, 2), 1'b0);
    set2(16'hFFFF, 16'h7FFF);
    run(1'b1, 3, mk(15, 3, 1), 1'b0);
    run(1'b0, 0, mk(0, 0, 1), 1'b0);

    // start held through DONE launches a second run from IDLE
    set2(16'h000F, 16'h00F0);
    @(negedge clk);
    max_gen = 16'd2;
    e = mk(8, 2, 1);
    e.issue = cyc;
    qa.push_back(e);
    start_a = 1'b1;
    repeat (5) @(negedge clk);
    e.issue = cyc;
    qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < e.issue + 8) @(negedge clk);
    chk("held start drain", qa.size(), 0);

    // abort mid-run
    @(negedge clk);
    max_gen = 16'd100;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-run busy", busy_a, 1);
    chk("mid-run ca_ce", ca_ce_a, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy_a, 0);
    chk("abort ca_ce", ca_ce_a, 0);
    chk("abort ca_load", ca_load_a, 0);
    chk("abort done", done_a, 0);
    chk("abort fitness", fit_a, 0);
    chk("abort gen_count", gen_a, 0);
    chk("abort status", st_a, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("after abort busy", busy_a, 0);

    for (int n = 0; n < 30; n++) begin
      randomize_seq();
      mg = $urandom_range(0, 12);
      run(1'b0, mg, model(mg, 24), n[0]);
    end
    for (int n = 0; n < 12; n++) begin
      randomize_seq();
      mg = $urandom_range(0, 12);
      run(1'b1, mg, model(mg, 4), n[0]);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
